// File: rtl/rx_dram_writer.sv
// -----------------------------------------------------------------------------
// rx_dram_writer
//   Drains complete packets from the RX FIFO stage, packs their 16-bit words
//   little-endian into DATA_WIDTH-bit beats and writes the beats into a
//   circular DRAM region through an Avalon-MM write master. The whole block
//   runs in the DRAM read/write clock domain.
//
// Ports
//   DRAM_RD_clk        clock
//   rst                synchronous, active-high reset
//   wr_enable          allows a new packet to start (sampled in IDLE only)
//   Buffer_Data_Ready  RX buffer holds a complete packet
//   RX_Buffer_empty    RX buffer empty
//   Buffer_RD_Data     RX buffer read data, valid the cycle after DRAM_RD_req
//   DRAM_RD_req        RX buffer pop request
//   avm_*              Avalon-MM write master (beat addressed)
//   pkt_done           one-cycle pulse per committed packet
//   pkt_count          committed packet count, wraps modulo 2^32
//   ring_wrapped       sticky: write pointer has wrapped at least once
//   pkt_overlen        sticky: a packet was cut at MAX_PKT_WORDS
// -----------------------------------------------------------------------------
module rx_dram_writer #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 25,
  parameter int BASE_ADDR     = 0,
  parameter int SPAN_BEATS    = 1048576,
  parameter int MAX_PKT_WORDS = 128
) (
  input  logic                    DRAM_RD_clk,
  input  logic                    rst,
  input  logic                    wr_enable,
  input  logic                    Buffer_Data_Ready,
  input  logic                    RX_Buffer_empty,
  input  logic [15:0]             Buffer_RD_Data,
  output logic                    DRAM_RD_req,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_write,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  input  logic                    avm_waitrequest,
  output logic                    pkt_done,
  output logic [31:0]             pkt_count,
  output logic                    ring_wrapped,
  output logic                    pkt_overlen
);

  localparam int LANES = DATA_WIDTH / 16;
  localparam int LW    = $clog2(LANES + 1);          // lane index may reach LANES (beat full)
  localparam int CW    = $clog2(MAX_PKT_WORDS + 1);  // word count may reach MAX_PKT_WORDS

  localparam logic [ADDR_WIDTH-1:0] BASE_PTR  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(BASE_ADDR + SPAN_BEATS - 1);
  localparam logic [LW-1:0]         FULL_LANE = LW'(LANES);
  localparam logic [LW-1:0]         LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0]         MAX_WORDS = CW'(MAX_PKT_WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POP     = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]              state_q,        state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q,          ptr_d;
  logic [LW-1:0]           lane_idx_q,     lane_idx_d;
  logic [CW-1:0]           word_cnt_q,     word_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q,         data_d;
  logic [DATA_WIDTH/8-1:0] be_q,           be_d;
  logic [31:0]             pkt_count_q,    pkt_count_d;
  logic                    ring_wrapped_q, ring_wrapped_d;
  logic                    pkt_overlen_q,  pkt_overlen_d;

  // NOTE: every signal gets its default at the top of the block so that no
  // path leaves a value unassigned; this is what keeps latches from inferring.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    lane_idx_d     = lane_idx_q;
    word_cnt_d     = word_cnt_q;
    data_d         = data_q;
    be_d           = be_q;
    pkt_count_d    = pkt_count_q;
    ring_wrapped_d = ring_wrapped_q;
    pkt_overlen_d  = pkt_overlen_q;

    case (state_q)
      S_IDLE: begin
        if (wr_enable && Buffer_Data_Ready && !RX_Buffer_empty) state_d = S_POP;
      end

      S_POP: state_d = S_CAPTURE;

      S_CAPTURE: begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_idx_q == LW'(i)) begin
            data_d[i*16 +: 16] = Buffer_RD_Data;
            be_d[i*2 +: 2]     = 2'b11;
          end
        end
        lane_idx_d = lane_idx_q + LW'(1);
        word_cnt_d = word_cnt_q + CW'(1);
        // Empty here reflects the buffer after the pop just taken.
        if (lane_idx_q == LAST_LANE || RX_Buffer_empty || word_cnt_d == MAX_WORDS)
          state_d = S_WRITE;
        else
          state_d = S_POP;
      end

      S_WRITE: begin
        if (!avm_waitrequest) begin
          if (ptr_q == LAST_PTR) begin
            ptr_d          = BASE_PTR;
            ring_wrapped_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
          end
          data_d     = '0;
          be_d       = '0;
          lane_idx_d = '0;
          // Only a full beat can be followed by more words of the same packet.
          if (lane_idx_q == FULL_LANE && !RX_Buffer_empty && word_cnt_q < MAX_WORDS)
            state_d = S_POP;
          else
            state_d = S_DONE;
        end
      end

      S_DONE: begin
        pkt_count_d = pkt_count_q + 32'd1;
        word_cnt_d  = '0;
        // Words left behind after a length cut start the next packet.
        if (word_cnt_q == MAX_WORDS && !RX_Buffer_empty) pkt_overlen_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge DRAM_RD_clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= BASE_PTR;
      lane_idx_q     <= '0;
      word_cnt_q     <= '0;
      data_q         <= '0;
      be_q           <= '0;
      pkt_count_q    <= '0;
      ring_wrapped_q <= 1'b0;
      pkt_overlen_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      lane_idx_q     <= lane_idx_d;
      word_cnt_q     <= word_cnt_d;
      data_q         <= data_d;
      be_q           <= be_d;
      pkt_count_q    <= pkt_count_d;
      ring_wrapped_q <= ring_wrapped_d;
      pkt_overlen_q  <= pkt_overlen_d;
    end
  end

  assign DRAM_RD_req    = (state_q == S_POP);
  assign avm_write      = (state_q == S_WRITE);
  assign pkt_done       = (state_q == S_DONE);
  assign avm_address    = ptr_q;
  assign avm_writedata  = data_q;
  assign avm_byteenable = be_q;
  assign pkt_count      = pkt_count_q;
  assign ring_wrapped   = ring_wrapped_q;
  assign pkt_overlen    = pkt_overlen_q;

endmodule

// File: tb/tb_rx_dram_writer.sv
// -----------------------------------------------------------------------------
// tb_rx_dram_writer
//   Directed bench for rx_dram_writer (LANES=4, ring of 16 beats at 0x100,
//   MAX_PKT_WORDS=128). A small RX buffer model serves pops; a monitor
//   records accepted Avalon beats and pkt_done pulses on the falling edge.
// -----------------------------------------------------------------------------
module tb_rx_dram_writer;

  localparam int DW   = 64;
  localparam int AW   = 25;
  localparam int BASE = 256;
  localparam int SPAN = 16;
  localparam int MAXW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_enable;
  logic          data_ready;
  logic          rx_empty;
  logic [15:0]   rd_data = '0;
  logic          rd_req;
  logic [AW-1:0] avm_address;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic [7:0]    avm_byteenable;
  logic          waitreq;
  logic          pkt_done;
  logic [31:0]   pkt_count;
  logic          ring_wrapped;
  logic          pkt_overlen;

  always #5 clk = ~clk;

  rx_dram_writer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .SPAN_BEATS(SPAN), .MAX_PKT_WORDS(MAXW)
  ) dut (
    .DRAM_RD_clk      (clk),
    .rst              (rst),
    .wr_enable        (wr_enable),
    .Buffer_Data_Ready(data_ready),
    .RX_Buffer_empty  (rx_empty),
    .Buffer_RD_Data   (rd_data),
    .DRAM_RD_req      (rd_req),
    .avm_address      (avm_address),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_waitrequest  (waitreq),
    .pkt_done         (pkt_done),
    .pkt_count        (pkt_count),
    .ring_wrapped     (ring_wrapped),
    .pkt_overlen      (pkt_overlen)
  );

  // RX buffer: stimulus writes mem/wr_ptr, the model owns rd_ptr.
  logic [15:0]   mem [0:511];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            pops   = 0;
  int            dones  = 0;
  logic [AW-1:0] mon_addr [$];
  logic [DW-1:0] mon_data [$];
  logic [7:0]    mon_be   [$];
  int            beat_idx = 0;
  int            n_vec    = 0;
  int            n_bad    = 0;

  assign rx_empty = (rd_ptr == wr_ptr);

  always @(negedge clk) begin
    if (rd_req) begin
      pops    <= pops + 1;
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
    if (avm_write && !waitreq) begin
      mon_addr.push_back(avm_address);
      mon_data.push_back(avm_writedata);
      mon_be.push_back(avm_byteenable);
    end
    if (pkt_done) dones <= dones + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && dones < target; i++) tick();
    check("pkt_done_count", 64'(dones), 64'(target));
    repeat (2) tick();
  endtask

  task automatic wait_write(input string tag);
    int n;
    n = 0;
    while (!avm_write && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(avm_write), 64'd1);
  endtask

  task automatic expect_beat(input string tag, input int addr, input logic [63:0] data,
                             input logic [7:0] be);
    if (beat_idx < mon_addr.size()) begin
      check({tag, "_addr"}, 64'(mon_addr[beat_idx]), 64'(addr));
      check({tag, "_data"}, mon_data[beat_idx], data);
      check({tag, "_be"},   64'(mon_be[beat_idx]), 64'(be));
      beat_idx++;
    end else begin
      check({tag, "_present"}, 64'(mon_addr.size()), 64'(beat_idx + 1));
    end
  endtask

  initial begin
    logic [63:0] exp_data;
    int          p0;

    rst        = 1'b1;
    wr_enable  = 1'b0;
    data_ready = 1'b0;
    waitreq    = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_write",   64'(avm_write),      64'd0);
    check("rst_req",     64'(rd_req),         64'd0);
    check("rst_addr",    64'(avm_address),    64'(BASE));
    check("rst_data",    avm_writedata,       64'd0);
    check("rst_be",      64'(avm_byteenable), 64'd0);
    check("rst_done",    64'(pkt_done),       64'd0);
    check("rst_count",   64'(pkt_count),      64'd0);
    check("rst_wrapped", 64'(ring_wrapped),   64'd0);
    check("rst_overlen", 64'(pkt_overlen),    64'd0);
    rst        = 1'b0;
    data_ready = 1'b1;
    tick();

    // 1: eight words, two full beats
    for (int i = 1; i <= 8; i++) push(16'(i));
    wr_enable = 1'b1;
    wait_done(1);
    wr_enable = 1'b0;
    expect_beat("t1_b0", BASE,     64'h0004_0003_0002_0001, 8'hFF);
    expect_beat("t1_b1", BASE + 1, 64'h0008_0007_0006_0005, 8'hFF);
    check("t1_count", 64'(pkt_count), 64'd1);
    check("t1_pops",  64'(pops),      64'd8);

    // 2: five words, partial second beat
    p0 = pops;
    for (int i = 0; i < 5; i++) push(16'(16'hA0 + i));
    wr_enable = 1'b1;
    wait_done(2);
    wr_enable = 1'b0;
    expect_beat("t2_b0", BASE + 2, 64'h00A3_00A2_00A1_00A0, 8'hFF);
    expect_beat("t2_b1", BASE + 3, 64'h0000_0000_0000_00A4, 8'h03);
    check("t2_pops",  64'(pops - p0), 64'd5);
    check("t2_count", 64'(pkt_count), 64'd2);

    // 3: three stall cycles on the only beat
    p0 = pops;
    for (int i = 0; i < 4; i++) push(16'(16'hB0 + i));
    waitreq   = 1'b1;
    wr_enable = 1'b1;
    wait_write("t3_write_seen");
    for (int k = 0; k < 4; k++) begin
      if (k == 3) waitreq = 1'b0;
      check("t3_hold_write", 64'(avm_write),   64'd1);
      check("t3_hold_addr",  64'(avm_address), 64'(BASE + 4));
      check("t3_hold_data",  avm_writedata,    64'h00B3_00B2_00B1_00B0);
      check("t3_hold_pops",  64'(pops - p0),   64'd4);
      tick();
    end
    check("t3_write_drop", 64'(avm_write), 64'd0);
    wait_done(3);
    wr_enable = 1'b0;
    expect_beat("t3_b0", BASE + 4, 64'h00B3_00B2_00B1_00B0, 8'hFF);
    check("t3_beats", 64'(mon_addr.size()), 64'd5);

    // Fill the ring up to its last beat: 40 words = beats 0x105..0x10E
    for (int i = 0; i < 40; i++) push(16'(16'h1000 + i));
    wr_enable = 1'b1;
    wait_done(4);
    wr_enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) exp_data[16*j +: 16] = 16'(16'h1000 + 4*k + j);
      expect_beat("fill", BASE + 5 + k, exp_data, 8'hFF);
    end
    check("fill_wrapped", 64'(ring_wrapped), 64'd0);

    // 4: packet at the last ring beat, next packet back at BASE
    for (int i = 0; i < 4; i++) push(16'(16'hD0 + i));
    wr_enable = 1'b1;
    wait_done(5);
    wr_enable = 1'b0;
    expect_beat("t4_last", BASE + SPAN - 1, 64'h00D3_00D2_00D1_00D0, 8'hFF);
    check("t4_wrapped", 64'(ring_wrapped), 64'd1);
    for (int i = 0; i < 4; i++) push(16'(16'hE0 + i));
    wr_enable = 1'b1;
    wait_done(6);
    wr_enable = 1'b0;
    expect_beat("t4_base", BASE, 64'h00E3_00E2_00E1_00E0, 8'hFF);

    // 5: 130 words -> 128-word packet, then the 2 leftovers as their own packet
    check("t5_overlen_pre", 64'(pkt_overlen), 64'd0);
    p0 = pops;
    for (int i = 0; i < 130; i++) push(16'(16'h2000 + i));
    wr_enable = 1'b1;
    wait_done(8);
    wr_enable = 1'b0;
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 4; j++) exp_data[16*j +: 16] = 16'(16'h2000 + 4*k + j);
      expect_beat("t5_long", BASE + ((1 + k) % SPAN), exp_data, 8'hFF);
    end
    expect_beat("t5_rest", BASE + 1, 64'h0000_0000_2081_2080, 8'h0F);
    check("t5_overlen", 64'(pkt_overlen), 64'd1);
    check("t5_pops",    64'(pops - p0),   64'd130);
    check("t5_count",   64'(pkt_count),   64'd8);

    // 6: reset while a beat is stalled in WRITE
    for (int i = 0; i < 8; i++) push(16'(16'hC0 + i));
    waitreq   = 1'b1;
    wr_enable = 1'b1;
    wait_write("t6_write_seen");
    rst = 1'b1;
    tick();
    check("t6_write",   64'(avm_write),      64'd0);
    check("t6_addr",    64'(avm_address),    64'(BASE));
    check("t6_data",    avm_writedata,       64'd0);
    check("t6_be",      64'(avm_byteenable), 64'd0);
    check("t6_count",   64'(pkt_count),      64'd0);
    check("t6_wrapped", 64'(ring_wrapped),   64'd0);
    check("t6_overlen", 64'(pkt_overlen),    64'd0);
    rst     = 1'b0;
    waitreq = 1'b0;
    wait_done(9);
    wr_enable = 1'b0;
    expect_beat("t6_after", BASE, 64'h00C7_00C6_00C5_00C4, 8'hFF);
    check("t6_count_after", 64'(pkt_count), 64'd1);
    check("t6_beats_total", 64'(mon_addr.size()), 64'(beat_idx));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
